bist_ctrl_param: RTL



---
 rtl/bist_pkg.sv | 35 +++
 rtl/galois_shreg.sv | 44 ++++
 rtl/bist_ctrl_param.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and helpers for the parametrised BIST controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        COMPARE,
        DONE
    } state_t;

    localparam logic [7:0] DEF_LFSR_POLY  = 8'h1D;
    localparam logic [7:0] DEF_LFSR_SEED  = 8'h01;
    localparam logic [7:0] DEF_MISR_POLY  = 8'h1D;
    localparam logic [7:0] DEF_GOLDEN_SIG = 8'h00;

    // One Galois step on a w-bit value held in the low bits of a 32-bit word.
    function automatic logic [31:0] galois_step(
        input logic [31:0] val,
        input int unsigned w,
        input logic [31:0] poly
    );
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        nxt  = (val << 1) & mask;
        if (((val >> (w - 1)) & 32'd1) != 32'd0) begin
            nxt = nxt ^ poly;
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/galois_shreg.sv
// Galois shift register with parallel XOR input; serves as LFSR (din=0) or MISR.
// Latency: one cycle per load/step.
// Backpressure: none; holds its value whenever neither load nor step is asserted.
module galois_shreg
    import bist_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] POLY    = W'(DEF_LFSR_POLY),
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [31:0]  step_v;

    always_comb begin
        q_d    = q_q;
        step_v = galois_step(32'(q_q), unsigned'(W), 32'(POLY));
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = W'(step_v) ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bist_ctrl_param.sv
// BIST session controller: LFSR pattern source, MISR response compactor, golden compare.
// Latency: start edge -> INIT next cycle; DONE N_PATTERNS+3 cycles after the edge sample.
// Backpressure: none; start edges outside IDLE/DONE are ignored.
module bist_ctrl_param
    import bist_pkg::*;
#(
    parameter int           N          = 8,
    parameter int           M          = 8,
    parameter int           N_PATTERNS = 255,
    parameter logic [N-1:0] LFSR_POLY  = N'(DEF_LFSR_POLY),
    parameter logic [N-1:0] LFSR_SEED  = N'(DEF_LFSR_SEED),
    parameter logic [M-1:0] MISR_POLY  = M'(DEF_MISR_POLY),
    parameter logic [M-1:0] GOLDEN_SIG = M'(DEF_GOLDEN_SIG)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] cut_resp,
    output logic [N-1:0] tpg,
    output logic         running,
    output logic         bist_end,
    output logic         pass,
    output logic [M-1:0] signature
);

    localparam int CW = $clog2(N_PATTERNS + 1);

    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass_q, pass_d;
    logic          start_edge;
    logic          shreg_load;
    logic          shreg_step;
    logic [N-1:0]  lfsr_val;
    logic [M-1:0]  misr_val;

    always_comb begin
        state_d    = state_q;
        start_d    = start;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        shreg_load = 1'b0;
        shreg_step = 1'b0;
        start_edge = start & ~start_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                shreg_load = 1'b1;
                cnt_d      = '0;
                pass_d     = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                shreg_step = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(N_PATTERNS - 1)) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                pass_d  = (misr_val == GOLDEN_SIG);
                state_d = DONE;
            end
            DONE: begin
                // Drop the stale verdict as soon as a new session is accepted.
                if (start_edge) begin
                    pass_d  = 1'b0;
                    state_d = INIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    galois_shreg #(
        .W       (N),
        .POLY    (LFSR_POLY),
        .RST_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (shreg_load),
        .load_val (LFSR_SEED),
        .step     (shreg_step),
        .din      ({N{1'b0}}),
        .q        (lfsr_val)
    );

    galois_shreg #(
        .W       (M),
        .POLY    (MISR_POLY),
        .RST_VAL ({M{1'b0}})
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (shreg_load),
        .load_val ({M{1'b0}}),
        .step     (shreg_step),
        .din      (cut_resp),
        .q        (misr_val)
    );

    assign tpg       = lfsr_val;
    assign signature = misr_val;
    assign pass      = pass_q;
    assign running   = (state_q == INIT) || (state_q == RUN) || (state_q == COMPARE);
    assign bist_end  = (state_q == DONE);

endmodule
